// File: rtl/mma_stream_pkg.sv
// Shared types and beat-count helpers for the MMA stream adapter.
// Holds the adapter FSM state enum and the stream geometry functions.
package mma_stream_pkg;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    function automatic int a_beats(int m, int k, int p, int bw);
        return (m * k * p) / bw;
    endfunction

    function automatic int b_beats(int k, int n, int p, int bw);
        return (k * n * p) / bw;
    endfunction

    function automatic int c_beats(int m, int n, int p, int bw);
        return (4 * p * m * n) / bw;
    endfunction

    function automatic int d_beats(int m, int n, int p, int bw);
        return (4 * p * m * n) / bw;
    endfunction

    // Counter width that stays legal for a single-beat stream.
    function automatic int cnt_w(int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mma_stream_adapter_if.sv
// Bundle of the operand stream, MMA handshakes, result stream and status.
// slave: adapter view; master: environment (interconnect + MMA) view.
interface mma_stream_adapter_if #(
    parameter int M      = 8,
    parameter int N      = 4,
    parameter int K      = 16,
    parameter int P      = 8,
    parameter int BEAT_W = 64
) ();

    logic                                  s_valid_i;
    logic [BEAT_W-1:0]                     s_data_i;
    logic                                  s_ready_o;

    logic signed [M-1:0][K-1:0][P-1:0]     A_o;
    logic signed [K-1:0][N-1:0][P-1:0]     B_o;
    logic signed [M-1:0][N-1:0][4*P-1:0]   C_o;
    logic                                  mma_valid_o;
    logic                                  mma_ready_i;

    logic signed [M-1:0][N-1:0][4*P-1:0]   D_i;
    logic                                  mma_valid_i;
    logic                                  mma_ready_o;

    logic                                  m_valid_o;
    logic [BEAT_W-1:0]                     m_data_o;
    logic                                  m_ready_i;

    logic                                  busy_o;
    logic [15:0]                           tiles_done_o;

    modport slave (
        input  s_valid_i, s_data_i,
        output s_ready_o,
        output A_o, B_o, C_o, mma_valid_o,
        input  mma_ready_i,
        input  D_i, mma_valid_i,
        output mma_ready_o,
        output m_valid_o, m_data_o,
        input  m_ready_i,
        output busy_o, tiles_done_o
    );

    modport master (
        output s_valid_i, s_data_i,
        input  s_ready_o,
        input  A_o, B_o, C_o, mma_valid_o,
        output mma_ready_i,
        output D_i, mma_valid_i,
        input  mma_ready_o,
        input  m_valid_o, m_data_o,
        output m_ready_i,
        input  busy_o, tiles_done_o
    );

endinterface

// File: rtl/mma_d_serializer.sv
// Result register and beat serializer for the D matrix.
// Ports: clk, rst_n, start (capture d), d, ready/valid/data stream, done pulse.
module mma_d_serializer
    import mma_stream_pkg::*;
#(
    parameter int BEAT_W  = 64,
    parameter int D_BEATS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [D_BEATS*BEAT_W-1:0] d,
    input  logic                      ready,
    output logic                      valid,
    output logic [BEAT_W-1:0]         data,
    output logic                      done
);

    localparam int OW = cnt_w(D_BEATS);
    localparam logic [OW-1:0] OUT_LAST = OW'(D_BEATS - 1);

    logic [D_BEATS-1:0][BEAT_W-1:0] res_q;
    logic [OW-1:0]                  out_cnt_q;
    logic                           active_q;
    logic                           hs;

    assign hs    = active_q & ready;
    assign done  = hs & (out_cnt_q == OUT_LAST);
    assign valid = active_q;
    assign data  = res_q[out_cnt_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            out_cnt_q <= '0;
            active_q  <= 1'b0;
        end else if (start) begin
            res_q     <= d;
            out_cnt_q <= '0;
            active_q  <= 1'b1;
        end else if (hs) begin
            if (out_cnt_q == OUT_LAST) begin
                out_cnt_q <= '0;
                active_q  <= 1'b0;
            end else begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mma_stream_adapter.sv
// Stream adapter: deserializes A/B/C beats, issues them to the MMA, and
// serializes D back out. Ports: clk_i, rst_ni, bus (mma_stream_adapter_if.slave).
module mma_stream_adapter
    import mma_stream_pkg::*;
#(
    parameter int M      = 8,
    parameter int N      = 4,
    parameter int K      = 16,
    parameter int P      = 8,
    parameter int BEAT_W = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    mma_stream_adapter_if.slave  bus
);

    localparam int A_BEATS  = a_beats(M, K, P, BEAT_W);
    localparam int B_BEATS  = b_beats(K, N, P, BEAT_W);
    localparam int C_BEATS  = c_beats(M, N, P, BEAT_W);
    localparam int D_BEATS  = d_beats(M, N, P, BEAT_W);
    localparam int IN_BEATS = A_BEATS + B_BEATS + C_BEATS;
    localparam int IW       = cnt_w(IN_BEATS);
    localparam logic [IW-1:0] IN_LAST = IW'(IN_BEATS - 1);

    if (((M * K * P) % BEAT_W) != 0 ||
        ((K * N * P) % BEAT_W) != 0 ||
        ((4 * P * M * N) % BEAT_W) != 0) begin : g_bad_geometry
        $error("mma_stream_adapter: matrix sizes not a multiple of BEAT_W");
    end

    state_t state_q, state_d;

    logic [IN_BEATS-1:0][BEAT_W-1:0] op_q;
    logic [IW-1:0]                   in_cnt_q;
    logic [15:0]                     tiles_q;
    // Holds s_ready low through reset and raises it on the first edge after.
    logic                            live_q;

    logic s_ready, mma_valid, mma_ready, busy;
    logic s_hs, issue_hs, res_hs, drain_done;

    assign s_hs     = bus.s_valid_i & s_ready;
    assign issue_hs = mma_valid & bus.mma_ready_i;
    assign res_hs   = mma_ready & bus.mma_valid_i;

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        mma_valid = 1'b0;
        mma_ready = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            LOAD: begin
                s_ready = live_q;
                busy    = (in_cnt_q != '0);
                if (s_hs && in_cnt_q == IN_LAST) state_d = ISSUE;
            end
            ISSUE: begin
                mma_valid = 1'b1;
                if (issue_hs) state_d = WAIT;
            end
            WAIT: begin
                mma_ready = 1'b1;
                if (res_hs) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= LOAD;
            in_cnt_q <= '0;
            op_q     <= '0;
            tiles_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            if (s_hs) begin
                op_q[in_cnt_q] <= bus.s_data_i;
                in_cnt_q <= (in_cnt_q == IN_LAST) ? '0 : in_cnt_q + 1'b1;
            end
            if (drain_done) tiles_q <= tiles_q + 16'd1;
        end
    end

    mma_d_serializer #(
        .BEAT_W  (BEAT_W),
        .D_BEATS (D_BEATS)
    ) u_ser (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .start (res_hs),
        .d     (bus.D_i),
        .ready (bus.m_ready_i),
        .valid (bus.m_valid_o),
        .data  (bus.m_data_o),
        .done  (drain_done)
    );

    // Operand beats are stored A, B, C in stream order, so each matrix is
    // a contiguous row-major slice of the operand register.
    assign bus.A_o          = op_q[A_BEATS-1:0];
    assign bus.B_o          = op_q[A_BEATS +: B_BEATS];
    assign bus.C_o          = op_q[A_BEATS+B_BEATS +: C_BEATS];
    assign bus.s_ready_o    = s_ready;
    assign bus.mma_valid_o  = mma_valid;
    assign bus.mma_ready_o  = mma_ready;
    assign bus.busy_o       = busy;
    assign bus.tiles_done_o = tiles_q;

endmodule

// File: tb/tb_mma_stream_adapter.sv
// Directed bench for mma_stream_adapter with default geometry.
// Drives the stream/MMA side through the interface and checks every output.
module tb_mma_stream_adapter;

    localparam int M = 8, N = 4, K = 16, P = 8, BW = 64;
    localparam int AB = 16, BB = 8, CB = 16, IB = 40, DB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [7:0]  am [128];
    logic [7:0]  bm [64];
    logic [31:0] cm [32];
    logic [31:0] dm [32];
    logic [63:0] ib [IB];
    logic [63:0] ob [DB];
    logic [M*N*32-1:0] df;

    mma_stream_adapter_if #(.M(M), .N(N), .K(K), .P(P), .BEAT_W(BW)) bus ();

    mma_stream_adapter #(.M(M), .N(N), .K(K), .P(P), .BEAT_W(BW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build();
        for (int b = 0; b < AB; b++)
            for (int q = 0; q < 8; q++) ib[b][q*8 +: 8] = am[b*8+q];
        for (int b = 0; b < BB; b++)
            for (int q = 0; q < 8; q++) ib[AB+b][q*8 +: 8] = bm[b*8+q];
        for (int b = 0; b < CB; b++)
            for (int q = 0; q < 2; q++) ib[AB+BB+b][q*32 +: 32] = cm[b*2+q];
        for (int j = 0; j < DB; j++) ob[j] = {dm[2*j+1], dm[2*j]};
        for (int e = 0; e < 32; e++) df[e*32 +: 32] = dm[e];
    endtask

    task automatic pat_basic();
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) am[i*K+k] = 8'(i + k);
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++) bm[k*N+n] = (k == n) ? 8'd1 : 8'd0;
        for (int e = 0; e < 32; e++) begin
            cm[e] = 32'd0;
            dm[e] = cm[e] + 32'd1;
        end
        build();
    endtask

    task automatic pat_mixed();
        for (int e = 0; e < 128; e++) am[e] = 8'(e * 7 + 3);
        for (int e = 0; e < 64; e++) bm[e] = 8'(e * 13 + 1);
        for (int e = 0; e < 32; e++) begin
            cm[e] = 32'(e) * 32'h0101_0101 - 32'd5;
            dm[e] = cm[e] + 32'd1;
        end
        build();
    endtask

    task automatic pat_neg();
        pat_basic();
        for (int e = 0; e < 32; e++) begin
            cm[e] = 32'hFFFF_FFFF;
            dm[e] = cm[e];
        end
        build();
    endtask

    task automatic chk_ops(input bit zero);
        logic [M*K*P-1:0]   af;
        logic [K*N*P-1:0]   bf;
        logic [M*N*4*P-1:0] cf;
        af = bus.A_o;
        bf = bus.B_o;
        cf = bus.C_o;
        for (int b = 0; b < AB; b++)
            chk("a_slice", af[b*64 +: 64], zero ? 64'd0 : ib[b]);
        for (int b = 0; b < BB; b++)
            chk("b_slice", bf[b*64 +: 64], zero ? 64'd0 : ib[AB+b]);
        for (int b = 0; b < CB; b++)
            chk("c_slice", cf[b*64 +: 64], zero ? 64'd0 : ib[AB+BB+b]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_s_ready", bus.s_ready_o, 1'b0);
        chk("rst_mma_valid", bus.mma_valid_o, 1'b0);
        chk("rst_mma_ready", bus.mma_ready_o, 1'b0);
        chk("rst_m_valid", bus.m_valid_o, 1'b0);
        chk("rst_m_data", bus.m_data_o, 64'd0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_tiles", bus.tiles_done_o, 16'd0);
        chk_ops(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", bus.s_ready_o, 1'b1);
    endtask

    task automatic feed(input int first, input int last);
        for (int b = first; b <= last; b++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = ib[b];
            chk("s_ready", bus.s_ready_o, 1'b1);
            @(negedge clk);
        end
        bus.s_valid_i = 1'b0;
    endtask

    task automatic issue_wait(input int stall);
        chk("mma_valid_rise", bus.mma_valid_o, 1'b1);
        chk("issue_s_ready", bus.s_ready_o, 1'b0);
        chk("issue_busy", bus.busy_o, 1'b1);
        chk_ops(1'b0);
        if (stall > 0) begin
            bus.mma_ready_i = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_mma_valid", bus.mma_valid_o, 1'b1);
                chk("stall_s_ready", bus.s_ready_o, 1'b0);
                chk_ops(1'b0);
            end
            bus.mma_ready_i = 1'b1;
        end
        @(negedge clk);
        chk("wait_mma_valid", bus.mma_valid_o, 1'b0);
        chk("wait_mma_ready", bus.mma_ready_o, 1'b1);
        bus.mma_valid_i = 1'b1;
        bus.D_i = df;
        @(negedge clk);
        bus.mma_valid_i = 1'b0;
        chk("drain_m_valid", bus.m_valid_o, 1'b1);
        chk("drain_mma_ready", bus.mma_ready_o, 1'b0);
    endtask

    task automatic drain(input int n, input bit toggle);
        int idx = 0;
        int t = 0;
        while (idx < n && t < 200) begin
            bus.m_ready_i = toggle ? t[0] : 1'b1;
            if (bus.m_valid_o) begin
                chk("m_data", bus.m_data_o, ob[idx]);
                if (bus.m_ready_i) idx++;
            end
            @(negedge clk);
            t++;
        end
        bus.m_ready_i = 1'b1;
        chk("drain_count", 64'(idx), 64'(n));
    endtask

    task automatic end_tile(input logic [15:0] tiles);
        chk("end_m_valid", bus.m_valid_o, 1'b0);
        chk("end_s_ready", bus.s_ready_o, 1'b1);
        chk("end_busy", bus.busy_o, 1'b0);
        chk("tiles_done", bus.tiles_done_o, tiles);
    endtask

    initial begin
        bus.s_valid_i   = 1'b0;
        bus.s_data_i    = '0;
        bus.mma_ready_i = 1'b1;
        bus.mma_valid_i = 1'b0;
        bus.D_i         = '0;
        bus.m_ready_i   = 1'b1;

        do_reset();

        bus.mma_valid_i = 1'b1;
        bus.D_i = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("spur_mma_ready", bus.mma_ready_o, 1'b0);
            chk("spur_m_valid", bus.m_valid_o, 1'b0);
            chk("spur_m_data", bus.m_data_o, 64'd0);
            chk("spur_busy", bus.busy_o, 1'b0);
        end
        bus.mma_valid_i = 1'b0;
        @(negedge clk);

        pat_basic();
        feed(0, IB-1);
        chk("a_7_15", bus.A_o[7][15], 64'd22);
        issue_wait(0);
        chk("beat0", bus.m_data_o, 64'h0000_0001_0000_0001);
        drain(DB, 1'b0);
        end_tile(16'd1);

        pat_mixed();
        feed(0, IB-1);
        issue_wait(10);
        drain(DB, 1'b1);
        end_tile(16'd2);

        pat_neg();
        feed(0, IB-1);
        issue_wait(0);
        chk("neg_beat0", bus.m_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        drain(DB, 1'b0);
        end_tile(16'd3);

        pat_mixed();
        feed(0, 19);
        chk("mid_load_busy", bus.busy_o, 1'b1);
        do_reset();
        pat_basic();
        feed(0, IB-1);
        issue_wait(0);
        drain(DB, 1'b0);
        end_tile(16'd1);

        pat_mixed();
        feed(0, IB-1);
        issue_wait(0);
        drain(5, 1'b0);
        chk("mid_drain_m_valid", bus.m_valid_o, 1'b1);
        do_reset();
        pat_mixed();
        feed(0, IB-1);
        issue_wait(0);
        drain(DB, 1'b1);
        end_tile(16'd1);

        dut.tiles_q = 16'hFFFE;
        @(negedge clk);
        pat_basic();
        feed(0, IB-1);
        issue_wait(0);
        drain(DB, 1'b0);
        end_tile(16'hFFFF);
        pat_neg();
        feed(0, IB-1);
        issue_wait(0);
        drain(DB, 1'b0);
        end_tile(16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
